// File: rtl/fb_write_sequencer.sv
// Serialises LINES-wide SPI packages into byte writes on the frame-buffer BRAM port A, framed by hsync/vsync.
// Define FB_WRITE_STATS_EN to latch per-frame written-byte and dropped-package counts.
module fb_write_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int HSIZE      = 640,
    parameter int VSIZE      = 360,
    parameter int ADDR_W     = $clog2(HSIZE*VSIZE)
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic [LINES-1:0][DATA_WIDTH-1:0]  pkg_data_in,
    input  logic                              pkg_valid_in,
    input  logic                              hsync_in,
    input  logic                              vsync_in,
    output logic [ADDR_W-1:0]                 wr_addr_out,
    output logic [DATA_WIDTH-1:0]             wr_data_out,
    output logic                              wr_en_out,
    output logic                              in_frame_out,
    output logic                              frame_done_out,
    output logic                              overflow_out,
    output logic                              clip_out,
    output logic [ADDR_W:0]                   frame_bytes_out,
    output logic [15:0]                       drop_count_out
);

    localparam int COL_W  = $clog2(HSIZE+1);
    localparam int ROW_W  = $clog2(VSIZE+1);
    localparam int LANE_W = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [COL_W-1:0]  HSIZE_C   = COL_W'(HSIZE);
    localparam logic [ROW_W-1:0]  VSIZE_C   = ROW_W'(VSIZE);
    localparam logic [ADDR_W:0]   HSIZE_B   = (ADDR_W+1)'(HSIZE);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LINES-1);

    typedef enum logic {WAIT_FRAME, IN_FRAME} state_t;
    typedef logic [LINES-1:0][DATA_WIDTH-1:0] pkg_t;

    state_t                r_state;
    logic                  r_hsync_d;
    logic                  r_vsync_d;
    pkg_t                  r_fifo_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;
    pkg_t                  r_cur;
    logic                  r_busy;
    logic [LANE_W-1:0]     r_lane;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      r_col;
    logic [ADDR_W:0]       r_row_base;
    logic                  r_line_pend;
    logic                  r_end_pend;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_en;
    logic                  r_frame_done;
    logic                  r_overflow;
    logic                  r_clip;

    logic                  w_vs_rise;
    logic                  w_vs_fall;
    logic                  w_hs_fall;
    logic                  w_in_frame;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_advance;
    logic                  w_take_ok;
    logic                  w_can_start;
    logic                  w_bypass;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_start;
    logic                  w_emit;
    logic                  w_in_window;
    logic                  w_write;
    logic                  w_drained;
    pkg_t                  w_start_pkg;
    logic [DATA_WIDTH-1:0] w_emit_byte;

    assign w_vs_rise    = vsync_in & ~r_vsync_d;
    assign w_vs_fall    = ~vsync_in & r_vsync_d;
    assign w_hs_fall    = ~hsync_in & r_hsync_d;
    assign w_in_frame   = (r_state == IN_FRAME);
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_fifo_full  = (r_count == 2'd2);

    // A pending row advance owns the idle slot between packages, so no package ever straddles two rows.
    assign w_advance    = w_in_frame & ~r_busy & r_line_pend & ~r_end_pend;
    assign w_take_ok    = w_in_frame & ~r_end_pend & pkg_valid_in;
    assign w_can_start  = w_in_frame & ~r_busy & ~w_advance;
    assign w_bypass     = w_can_start & w_fifo_empty & w_take_ok;
    assign w_pop        = w_can_start & ~w_fifo_empty;
    assign w_push       = w_take_ok & ~w_bypass & (~w_fifo_full | w_pop);
    assign w_drop       = w_take_ok & w_fifo_full & ~w_pop;
    assign w_start      = w_bypass | w_pop;
    assign w_emit       = w_start | r_busy;
    assign w_start_pkg  = w_pop ? r_fifo_mem[r_rd_ptr] : pkg_data_in;
    assign w_emit_byte  = w_start ? w_start_pkg[0] : r_cur[r_lane];
    assign w_in_window  = (r_col < HSIZE_C) & (r_row < VSIZE_C);
    assign w_write      = w_emit & w_in_window;
    assign w_drained    = w_in_frame & r_end_pend & w_fifo_empty & ~r_busy;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= WAIT_FRAME;
            r_hsync_d     <= 1'b0;
            r_vsync_d     <= 1'b0;
            r_fifo_mem[0] <= '0;
            r_fifo_mem[1] <= '0;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_count       <= 2'd0;
            r_cur         <= '0;
            r_busy        <= 1'b0;
            r_lane        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_row_base    <= '0;
            r_line_pend   <= 1'b0;
            r_end_pend    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_en       <= 1'b0;
            r_frame_done  <= 1'b0;
            r_overflow    <= 1'b0;
            r_clip        <= 1'b0;
        end else begin
            r_hsync_d    <= hsync_in;
            r_vsync_d    <= vsync_in;
            r_frame_done <= 1'b0;
            r_wr_en      <= 1'b0;

            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= pkg_data_in;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            // Lane 0 goes out on the start cycle itself; the rest follow from r_cur.
            if (w_start) begin
                r_cur <= w_start_pkg;
                if (LINES > 1) begin
                    r_busy <= 1'b1;
                    r_lane <= LANE_W'(1);
                end
            end else if (r_busy) begin
                if (r_lane == LAST_LANE) begin
                    r_busy <= 1'b0;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                end
            end

            if (w_emit) begin
                r_wr_data <= w_emit_byte;
                if (w_in_window) begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= ADDR_W'(r_row_base + (ADDR_W+1)'(r_col));
                    r_col     <= r_col + COL_W'(1);
                end else begin
                    r_clip <= 1'b1;
                end
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                WAIT_FRAME: begin
                    if (w_vs_rise) begin
                        r_state     <= IN_FRAME;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_row_base  <= '0;
                        r_overflow  <= 1'b0;
                        r_clip      <= 1'b0;
                        r_line_pend <= 1'b0;
                        r_end_pend  <= 1'b0;
                    end
                end
                IN_FRAME: begin
                    if (w_advance) begin
                        r_col <= '0;
                        if (r_row != VSIZE_C) begin
                            r_row      <= r_row + ROW_W'(1);
                            r_row_base <= r_row_base + HSIZE_B;
                        end
                    end
                    // Line ends seen during the end-of-frame drain are meaningless and discarded.
                    if (r_end_pend) begin
                        r_line_pend <= 1'b0;
                    end else if (w_hs_fall) begin
                        r_line_pend <= 1'b1;
                    end else if (w_advance) begin
                        r_line_pend <= 1'b0;
                    end
                    if (w_vs_fall) begin
                        r_end_pend <= 1'b1;
                    end
                    if (w_drained) begin
                        r_state      <= WAIT_FRAME;
                        r_end_pend   <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef FB_WRITE_STATS_EN
    logic [ADDR_W:0] r_acc_bytes;
    logic [15:0]     r_acc_drops;
    logic [ADDR_W:0] r_frame_bytes;
    logic [15:0]     r_drop_count;

    // Accumulators restart at frame start; the published values only move on frame completion.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_acc_bytes   <= '0;
            r_acc_drops   <= '0;
            r_frame_bytes <= '0;
            r_drop_count  <= '0;
        end else begin
            if (!w_in_frame && w_vs_rise) begin
                r_acc_bytes <= '0;
                r_acc_drops <= '0;
            end else begin
                if (w_write) begin
                    r_acc_bytes <= r_acc_bytes + (ADDR_W+1)'(1);
                end
                if (w_drop && (r_acc_drops != 16'hFFFF)) begin
                    r_acc_drops <= r_acc_drops + 16'd1;
                end
            end
            if (w_drained) begin
                r_frame_bytes <= r_acc_bytes;
                r_drop_count  <= r_acc_drops;
            end
        end
    end

    assign frame_bytes_out = r_frame_bytes;
    assign drop_count_out  = r_drop_count;
`else
    assign frame_bytes_out = '0;
    assign drop_count_out  = '0;
`endif

    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign wr_en_out      = r_wr_en;
    assign in_frame_out   = w_in_frame;
    assign frame_done_out = r_frame_done;
    assign overflow_out   = r_overflow;
    assign clip_out       = r_clip;

endmodule

// File: tb/tb_fb_write_sequencer.sv
// Directed bench for fb_write_sequencer with a small 16x2 frame so row-advance, clipping and saturation are reachable.
// Stats expectations follow FB_WRITE_STATS_EN.
module tb_fb_write_sequencer;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int HS = 16;
    localparam int VS = 2;
    localparam int AW = $clog2(HS*VS);

`ifdef FB_WRITE_STATS_EN
    localparam int EXP_BYTES = 20;
    localparam int EXP_DROPS = 2;
`else
    localparam int EXP_BYTES = 0;
    localparam int EXP_DROPS = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rstN;
    logic [LN-1:0][DW-1:0]  pkgData;
    logic                   pkgValid;
    logic                   hsync;
    logic                   vsync;
    logic [AW-1:0]          wrAddr;
    logic [DW-1:0]          wrData;
    logic                   wrEn;
    logic                   inFrame;
    logic                   frameDone;
    logic                   overflow;
    logic                   clip;
    logic [AW:0]            frameBytes;
    logic [15:0]            dropCount;

    int checks = 0;
    int failures = 0;
    int writeCount = 0;
    int base = 0;
    int sel [4] = '{0, 1, 2, 4};
    logic [AW-1:0] addrLog [128];
    logic [DW-1:0] dataLog [128];
    logic [31:0]   pkg;

    fb_write_sequencer #(
        .DATA_WIDTH (DW),
        .LINES      (LN),
        .HSIZE      (HS),
        .VSIZE      (VS)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rstN),
        .pkg_data_in     (pkgData),
        .pkg_valid_in    (pkgValid),
        .hsync_in        (hsync),
        .vsync_in        (vsync),
        .wr_addr_out     (wrAddr),
        .wr_data_out     (wrData),
        .wr_en_out       (wrEn),
        .in_frame_out    (inFrame),
        .frame_done_out  (frameDone),
        .overflow_out    (overflow),
        .clip_out        (clip),
        .frame_bytes_out (frameBytes),
        .drop_count_out  (dropCount)
    );

    always #5 clk = ~clk;

    // Log every BRAM write, sampled mid-cycle where registered outputs are stable.
    always @(negedge clk) begin
        if (wrEn === 1'b1) begin
            if (writeCount < 128) begin
                addrLog[writeCount] = wrAddr;
                dataLog[writeCount] = wrData;
            end
            writeCount = writeCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] makePkg(input int tag);
        logic [31:0] p;
        for (int l = 0; l < LN; l++) begin
            p[l*8 +: 8] = 8'(tag*16 + l);
        end
        return p;
    endfunction

    // One-cycle package strobe; returns on the cycle where lane 0 would be on the write port.
    task automatic applyStimulus(input logic [31:0] p);
        @(negedge clk);
        pkgData  = p;
        pkgValid = 1'b1;
        @(negedge clk);
        pkgValid = 1'b0;
    endtask

    task automatic startFrame();
        @(negedge clk);
        vsync = 1'b1;
        hsync = 1'b1;
        @(negedge clk);
    endtask

    task automatic endLine();
        @(negedge clk);
        hsync = 1'b0;
        @(negedge clk);
        hsync = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitFrameDone(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frameDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic endFrame(input string tag);
        @(negedge clk);
        vsync = 1'b0;
        waitFrameDone(tag);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN     = 1'b0;
        pkgData  = '0;
        pkgValid = 1'b0;
        hsync    = 1'b0;
        vsync    = 1'b0;
        #12;
        checkOutput("rst_wr_en",       32'(wrEn),       32'd0);
        checkOutput("rst_wr_addr",     32'(wrAddr),     32'd0);
        checkOutput("rst_in_frame",    32'(inFrame),    32'd0);
        checkOutput("rst_overflow",    32'(overflow),   32'd0);
        checkOutput("rst_clip",        32'(clip),       32'd0);
        checkOutput("rst_frame_done",  32'(frameDone),  32'd0);
        checkOutput("rst_frame_bytes", 32'(frameBytes), 32'd0);
        checkOutput("rst_drop_count",  32'(dropCount),  32'd0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_in_frame", 32'(inFrame), 32'd0);

        $display("[TB] single package latency and ordering");
        startFrame();
        checkOutput("t1_in_frame", 32'(inFrame), 32'd1);
        pkg = 32'h4433_2211;
        applyStimulus(pkg);
        for (int k = 0; k < LN; k++) begin
            checkOutput($sformatf("t1_wr_en_lane%0d", k), 32'(wrEn),   32'd1);
            checkOutput($sformatf("t1_addr_lane%0d", k),  32'(wrAddr), 32'(k));
            checkOutput($sformatf("t1_data_lane%0d", k),  32'(wrData), 32'(pkg[k*8 +: 8]));
            @(negedge clk);
        end
        checkOutput("t1_wr_en_after", 32'(wrEn), 32'd0);
        endFrame("t1_frame_done");
        @(negedge clk);
        checkOutput("t1_done_pulse_width", 32'(frameDone), 32'd0);
        checkOutput("t1_back_to_wait",     32'(inFrame),   32'd0);

        $display("[TB] column clip, row advance, row saturation");
        startFrame();
        #1 base = writeCount;
        for (int p = 1; p <= 4; p++) begin
            applyStimulus(makePkg(p));
            repeat (5) @(negedge clk);
        end
        #1;
        checkOutput("t2_row0_writes",    32'(writeCount - base),      32'd16);
        checkOutput("t2_clip_before",    32'(clip),                   32'd0);
        checkOutput("t2_last_addr_row0", 32'(addrLog[base+15]),       32'd15);
        checkOutput("t2_last_data_row0", 32'(dataLog[base+15]),       32'h43);
        applyStimulus(makePkg(5));
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t2_clipped_writes", 32'(writeCount - base), 32'd16);
        checkOutput("t2_clip_set",       32'(clip),              32'd1);
        endLine();
        applyStimulus(makePkg(6));
        for (int k = 0; k < LN; k++) begin
            checkOutput($sformatf("t2_row1_wr_en%0d", k), 32'(wrEn),   32'd1);
            checkOutput($sformatf("t2_row1_addr%0d", k),  32'(wrAddr), 32'(16 + k));
            checkOutput($sformatf("t2_row1_data%0d", k),  32'(wrData), 32'(8'h60 + k));
            @(negedge clk);
        end
        endLine();
        applyStimulus(makePkg(7));
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t2_row_saturated_writes", 32'(writeCount - base), 32'd20);
        endFrame("t2_frame_done");

        $display("[TB] back-to-back packages, FIFO overflow, stats");
        startFrame();
        #1 base = writeCount;
        checkOutput("t3_overflow_cleared", 32'(overflow), 32'd0);
        checkOutput("t3_clip_cleared",     32'(clip),     32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) checkOutput("t3_overflow_before_drop", 32'(overflow), 32'd0);
            if (i == 4) checkOutput("t3_overflow_after_drop",  32'(overflow), 32'd1);
            pkgData  = makePkg(i);
            pkgValid = 1'b1;
        end
        @(negedge clk);
        pkgValid = 1'b0;
        repeat (16) @(negedge clk);
        #1;
        checkOutput("t3_burst_writes", 32'(writeCount - base), 32'd16);
        for (int j = 0; j < 16; j++) begin
            checkOutput($sformatf("t3_addr%0d", j), 32'(addrLog[base+j]), 32'(j));
            checkOutput($sformatf("t3_data%0d", j), 32'(dataLog[base+j]), 32'(sel[j/4]*16 + j%4));
        end
        endLine();
        applyStimulus(makePkg(7));
        repeat (4) @(negedge clk);
        #1;
        checkOutput("t3_total_writes",    32'(writeCount - base),  32'd20);
        checkOutput("t3_row1_last_addr",  32'(addrLog[base+19]),   32'd19);
        endFrame("t3_frame_done");
        checkOutput("t3_frame_bytes",  32'(frameBytes), 32'(EXP_BYTES));
        checkOutput("t3_drop_count",   32'(dropCount),  32'(EXP_DROPS));
        checkOutput("t3_overflow_kept", 32'(overflow),  32'd1);
        checkOutput("t3_clip_clear",    32'(clip),      32'd0);
        @(negedge clk);
        checkOutput("t3_stats_held", 32'(frameBytes), 32'(EXP_BYTES));

        $display("[TB] end of frame during unpack");
        startFrame();
        #1 base = writeCount;
        @(negedge clk);
        pkgData  = makePkg(8);
        pkgValid = 1'b1;
        @(negedge clk);
        pkgData  = makePkg(9);
        @(negedge clk);
        pkgValid = 1'b0;
        vsync    = 1'b0;
        @(negedge clk);
        pkgData  = makePkg(10);
        pkgValid = 1'b1;
        @(negedge clk);
        pkgValid = 1'b0;
        waitFrameDone("t4_frame_done");
        #1;
        checkOutput("t4_drained_writes",   32'(writeCount - base), 32'd8);
        checkOutput("t4_last_addr",        32'(addrLog[base+7]),   32'd7);
        checkOutput("t4_last_data",        32'(dataLog[base+7]),   32'h93);
        checkOutput("t4_silent_drop",      32'(overflow),          32'd0);
        @(negedge clk);
        checkOutput("t4_done_pulse_width", 32'(frameDone), 32'd0);
        checkOutput("t4_wait_frame",       32'(inFrame),   32'd0);
        applyStimulus(makePkg(11));
        repeat (5) @(negedge clk);
        #1;
        checkOutput("t4_no_write_after", 32'(writeCount - base), 32'd8);

        $display("[TB] asynchronous reset mid-unpack");
        startFrame();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pkgData  = makePkg(i + 1);
            pkgValid = 1'b1;
        end
        @(negedge clk);
        pkgValid = 1'b0;
        checkOutput("t5_pre_wr_en",    32'(wrEn),     32'd1);
        checkOutput("t5_pre_overflow", 32'(overflow), 32'd1);
        #2;
        rstN  = 1'b0;
        vsync = 1'b0;
        hsync = 1'b0;
        #1;
        checkOutput("t5_async_wr_en",    32'(wrEn),     32'd0);
        checkOutput("t5_async_overflow", 32'(overflow), 32'd0);
        checkOutput("t5_async_in_frame", 32'(inFrame),  32'd0);
        checkOutput("t5_async_clip",     32'(clip),     32'd0);
        @(negedge clk);
        rstN = 1'b1;
        #1 base = writeCount;
        applyStimulus(makePkg(5));
        repeat (6) @(negedge clk);
        #1;
        checkOutput("t5_no_write_after_reset", 32'(writeCount - base), 32'd0);
        checkOutput("t5_still_waiting",        32'(inFrame),           32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
